// File: rtl/riviera_pkg.sv
// Shared RV64I definitions for the riviera pipeline: opcodes, immediate formats,
// control bundle and the immediate generator.
package riviera_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned NREGS = 32;

  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
    logic alusrc;
    logic branch;
    logic jump;
    logic jalr;
    logic word_op;
  } ctrl_t;

  function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] instr, input imm_type_e t);
    logic [XLEN-1:0] imm;
    case (t)
      IMM_I:   imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
      IMM_J:   imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/id_stage_reg_file.sv
// 32 x XLEN register file: two combinational reads, one synchronous write,
// x0 hardwired to zero, write-through bypass from the write port.
module reg_file
  import riviera_pkg::*;
#(
  parameter int unsigned W = XLEN,
  parameter int unsigned N = NREGS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [4:0]   i_rs1,
  input  logic [4:0]   i_rs2,
  output logic [W-1:0] o_rs1_data,
  output logic [W-1:0] o_rs2_data,
  input  logic         i_wen,
  input  logic [4:0]   i_wd,
  input  logic [W-1:0] i_wdata
);

  logic [W-1:0] r_regs [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) r_regs[i] <= '0;
    end else if (i_wen && (i_wd != 5'd0)) begin
      r_regs[i_wd] <= i_wdata;
    end
  end

  always_comb begin
    o_rs1_data = '0;
    if (i_rs1 != 5'd0) o_rs1_data = (i_wen && (i_wd == i_rs1)) ? i_wdata : r_regs[i_rs1];
  end

  always_comb begin
    o_rs2_data = '0;
    if (i_rs2 != 5'd0) o_rs2_data = (i_wen && (i_wd == i_rs2)) ? i_wdata : r_regs[i_rs2];
  end

endmodule

// File: rtl/id_stage.sv
// RV64I decode stage: decode, immediates, register read, load-use stall, early JAL
// redirect and the ID/EX register. Define ID_PERF_CNT_EN for stall/flush counters.
module id_stage
  import riviera_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_if_valid,
  input  logic [31:0]     i_if_instr,
  input  logic [XLEN-1:0] i_if_pc,
  input  logic            i_PCsrc,
  input  logic            i_ex_memread,
  input  logic [4:0]      i_ex_rd,
  input  logic            i_wb_wen,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  output logic            o_id_ready,
  output logic            o_is_jump,
  output logic [XLEN-1:0] o_id_PC,
  output logic            o_idex_valid,
  output logic [XLEN-1:0] o_idex_pc,
  output logic [XLEN-1:0] o_idex_rs1_data,
  output logic [XLEN-1:0] o_idex_rs2_data,
  output logic [XLEN-1:0] o_idex_imm,
  output logic [4:0]      o_idex_rs1,
  output logic [4:0]      o_idex_rs2,
  output logic [4:0]      o_idex_rd,
  output logic [2:0]      o_idex_funct3,
  output logic            o_idex_funct7b5,
  output ctrl_t           o_idex_ctrl
`ifdef ID_PERF_CNT_EN
  ,
  output logic [31:0]     o_stall_cnt,
  output logic [31:0]     o_flush_cnt
`endif
);

  logic [6:0]      w_opcode;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  ctrl_t           w_ctrl;
  imm_type_e       w_imm_type;
  logic            w_use_rs1;
  logic            w_use_rs2;
  logic            w_legal;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;
  logic            w_hazard;
  logic            w_issue;

  assign w_opcode = i_if_instr[6:0];
  assign w_rs1    = i_if_instr[19:15];
  assign w_rs2    = i_if_instr[24:20];
  assign w_rd     = i_if_instr[11:7];

  always_comb begin
    w_ctrl     = '0;
    w_imm_type = IMM_NONE;
    w_use_rs1  = 1'b0;
    w_use_rs2  = 1'b0;
    w_legal    = 1'b1;
    case (w_opcode)
      OP, OP_32: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.word_op  = (w_opcode == OP_32);
        w_use_rs1       = 1'b1;
        w_use_rs2       = 1'b1;
      end
      OP_IMM, OP_IMM_32: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.alusrc   = 1'b1;
        w_ctrl.word_op  = (w_opcode == OP_IMM_32);
        w_imm_type      = IMM_I;
        w_use_rs1       = 1'b1;
      end
      LOAD: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.memread  = 1'b1;
        w_ctrl.memtoreg = 1'b1;
        w_ctrl.alusrc   = 1'b1;
        w_imm_type      = IMM_I;
        w_use_rs1       = 1'b1;
      end
      STORE: begin
        w_ctrl.memwrite = 1'b1;
        w_ctrl.alusrc   = 1'b1;
        w_imm_type      = IMM_S;
        w_use_rs1       = 1'b1;
        w_use_rs2       = 1'b1;
      end
      BRANCH: begin
        w_ctrl.branch = 1'b1;
        w_imm_type    = IMM_B;
        w_use_rs1     = 1'b1;
        w_use_rs2     = 1'b1;
      end
      JAL: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.jump     = 1'b1;
        w_imm_type      = IMM_J;
      end
      JALR: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.jalr     = 1'b1;
        w_ctrl.alusrc   = 1'b1;
        w_imm_type      = IMM_I;
        w_use_rs1       = 1'b1;
      end
      LUI, AUIPC: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.alusrc   = 1'b1;
        w_imm_type      = IMM_U;
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_imm   = gen_imm(i_if_instr, w_imm_type);
  assign w_imm_j = gen_imm(i_if_instr, IMM_J);

  reg_file #(.W(XLEN), .N(NREGS)) u_rf (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rs1      (w_rs1),
    .i_rs2      (w_rs2),
    .o_rs1_data (w_rs1_data),
    .o_rs2_data (w_rs2_data),
    .i_wen      (i_wb_wen),
    .i_wd       (i_wb_rd),
    .i_wdata    (i_wb_data)
  );

  assign w_hazard = i_ex_memread && (i_ex_rd != 5'd0) && i_if_valid &&
                    ((w_use_rs1 && (i_ex_rd == w_rs1)) || (w_use_rs2 && (i_ex_rd == w_rs2)));
  assign w_issue  = i_if_valid && w_legal && !i_PCsrc && !w_hazard;

  // Flush keeps ready high so fetch never sees a stall that would mask the redirect.
  assign o_id_ready = !rst_n || i_PCsrc || !w_hazard;
  assign o_is_jump  = rst_n && i_if_valid && (w_opcode == JAL) && !w_hazard && !i_PCsrc;
  assign o_id_PC    = rst_n ? (i_if_pc + w_imm_j) : '0;

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;
  logic [2:0]      r_funct3;
  logic            r_funct7b5;
  ctrl_t           r_ctrl;

  // Bubbles clear the whole payload, not just valid/ctrl.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_funct3   <= '0;
      r_funct7b5 <= 1'b0;
      r_ctrl     <= '0;
    end else if (w_issue) begin
      r_valid    <= 1'b1;
      r_pc       <= i_if_pc;
      r_rs1_data <= w_rs1_data;
      r_rs2_data <= w_rs2_data;
      r_imm      <= w_imm;
      r_rs1      <= w_rs1;
      r_rs2      <= w_rs2;
      r_rd       <= w_rd;
      r_funct3   <= i_if_instr[14:12];
      r_funct7b5 <= i_if_instr[30];
      r_ctrl     <= w_ctrl;
    end else begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_funct3   <= '0;
      r_funct7b5 <= 1'b0;
      r_ctrl     <= '0;
    end
  end

  assign o_idex_valid    = r_valid;
  assign o_idex_pc       = r_pc;
  assign o_idex_rs1_data = r_rs1_data;
  assign o_idex_rs2_data = r_rs2_data;
  assign o_idex_imm      = r_imm;
  assign o_idex_rs1      = r_rs1;
  assign o_idex_rs2      = r_rs2;
  assign o_idex_rd       = r_rd;
  assign o_idex_funct3   = r_funct3;
  assign o_idex_funct7b5 = r_funct7b5;
  assign o_idex_ctrl     = r_ctrl;

`ifdef ID_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_hazard && !i_PCsrc && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (i_PCsrc && i_if_valid && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_id_stage.sv
// Table-driven bench for id_stage with a scoreboard queue for the ID/EX register.
// Also builds with ID_PERF_CNT_EN defined to check the perf counters.
module tb_id_stage;
  import riviera_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        i_if_valid;
  logic [31:0] i_if_instr;
  logic [63:0] i_if_pc;
  logic        i_PCsrc;
  logic        i_ex_memread;
  logic [4:0]  i_ex_rd;
  logic        i_wb_wen;
  logic [4:0]  i_wb_rd;
  logic [63:0] i_wb_data;
  logic        o_id_ready;
  logic        o_is_jump;
  logic [63:0] o_id_PC;
  logic        o_idex_valid;
  logic [63:0] o_idex_pc, o_idex_rs1_data, o_idex_rs2_data, o_idex_imm;
  logic [4:0]  o_idex_rs1, o_idex_rs2, o_idex_rd;
  logic [2:0]  o_idex_funct3;
  logic        o_idex_funct7b5;
  ctrl_t       o_idex_ctrl;
  logic [8:0]  w_ctrl_bits;
`ifdef ID_PERF_CNT_EN
  logic [31:0] o_stall_cnt;
  logic [31:0] o_flush_cnt;
`endif

  assign w_ctrl_bits = o_idex_ctrl;

  id_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_if_valid      (i_if_valid),
    .i_if_instr      (i_if_instr),
    .i_if_pc         (i_if_pc),
    .i_PCsrc         (i_PCsrc),
    .i_ex_memread    (i_ex_memread),
    .i_ex_rd         (i_ex_rd),
    .i_wb_wen        (i_wb_wen),
    .i_wb_rd         (i_wb_rd),
    .i_wb_data       (i_wb_data),
    .o_id_ready      (o_id_ready),
    .o_is_jump       (o_is_jump),
    .o_id_PC         (o_id_PC),
    .o_idex_valid    (o_idex_valid),
    .o_idex_pc       (o_idex_pc),
    .o_idex_rs1_data (o_idex_rs1_data),
    .o_idex_rs2_data (o_idex_rs2_data),
    .o_idex_imm      (o_idex_imm),
    .o_idex_rs1      (o_idex_rs1),
    .o_idex_rs2      (o_idex_rs2),
    .o_idex_rd       (o_idex_rd),
    .o_idex_funct3   (o_idex_funct3),
    .o_idex_funct7b5 (o_idex_funct7b5),
    .o_idex_ctrl     (o_idex_ctrl)
`ifdef ID_PERF_CNT_EN
    ,
    .o_stall_cnt     (o_stall_cnt),
    .o_flush_cnt     (o_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [31:0] instr;
    logic [63:0] pc;
    logic        pcsrc;
    logic        exmr;
    logic [4:0]  exrd;
    logic        wen;
    logic [4:0]  wrd;
    logic [63:0] wdata;
    logic        e_ready;
    logic        e_jump;
    logic [63:0] e_idpc;
    logic        e_valid;
    logic [8:0]  e_ctrl;
    logic [63:0] e_rs1;
    logic [63:0] e_rs2;
    logic [63:0] e_imm;
    logic [4:0]  e_rd;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [63:0] pc;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic [8:0]  ctrl;
  } exp_t;

  int unsigned checks = 0;
  int unsigned failures = 0;
  vec_t vecs[$];
  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic vld, input logic [31:0] instr, input logic [63:0] pc,
                              input logic pcsrc, input logic exmr, input logic [4:0] exrd,
                              input logic wen, input logic [4:0] wrd, input logic [63:0] wdata,
                              input logic e_ready, input logic e_jump, input logic [63:0] e_idpc,
                              input logic e_valid, input logic [8:0] e_ctrl, input logic [63:0] e_rs1,
                              input logic [63:0] e_rs2, input logic [63:0] e_imm, input logic [4:0] e_rd);
    vec_t v;
    v.vld = vld; v.instr = instr; v.pc = pc; v.pcsrc = pcsrc; v.exmr = exmr; v.exrd = exrd;
    v.wen = wen; v.wrd = wrd; v.wdata = wdata;
    v.e_ready = e_ready; v.e_jump = e_jump; v.e_idpc = e_idpc; v.e_valid = e_valid;
    v.e_ctrl = e_ctrl; v.e_rs1 = e_rs1; v.e_rs2 = e_rs2; v.e_imm = e_imm; v.e_rd = e_rd;
    return v;
  endfunction

  // Drive one ID cycle, check the combinational fetch-side outputs, then
  // check the ID/EX contents one cycle later via the scoreboard.
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    exp_t g;
    i_if_valid   = v.vld;
    i_if_instr   = v.instr;
    i_if_pc      = v.pc;
    i_PCsrc      = v.pcsrc;
    i_ex_memread = v.exmr;
    i_ex_rd      = v.exrd;
    i_wb_wen     = v.wen;
    i_wb_rd      = v.wrd;
    i_wb_data    = v.wdata;
    #2;
    chk($sformatf("v%0d.ready", idx), 64'(o_id_ready), 64'(v.e_ready));
    chk($sformatf("v%0d.is_jump", idx), 64'(o_is_jump), 64'(v.e_jump));
    if (v.e_jump) chk($sformatf("v%0d.id_PC", idx), o_id_PC, v.e_idpc);
    e.valid = v.e_valid;
    e.pc    = v.e_valid ? v.pc : 64'd0;
    e.rs1   = v.e_rs1;
    e.rs2   = v.e_rs2;
    e.imm   = v.e_imm;
    e.rd    = v.e_rd;
    e.ctrl  = v.e_ctrl;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk($sformatf("v%0d.idex_valid", idx), 64'(o_idex_valid), 64'(g.valid));
    chk($sformatf("v%0d.idex_ctrl", idx), 64'(w_ctrl_bits), 64'(g.ctrl));
    chk($sformatf("v%0d.idex_pc", idx), o_idex_pc, g.pc);
    chk($sformatf("v%0d.idex_rs1_data", idx), o_idex_rs1_data, g.rs1);
    chk($sformatf("v%0d.idex_rs2_data", idx), o_idex_rs2_data, g.rs2);
    chk($sformatf("v%0d.idex_imm", idx), o_idex_imm, g.imm);
    chk($sformatf("v%0d.idex_rd", idx), 64'(o_idex_rd), 64'(g.rd));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Register setup: x5=0x1234, x1=0x11, x2=0x22, x7=0x77, x0 write ignored
    vecs.push_back(mk(0, 32'h0, 64'h0, 0, 0, 0, 1, 5, 64'h1234, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0, 64'h0, 0, 0, 0, 1, 1, 64'h11,   1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0, 64'h0, 0, 0, 0, 1, 2, 64'h22,   1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0, 64'h0, 0, 0, 0, 1, 7, 64'h77,   1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0, 64'h0, 0, 0, 0, 1, 0, 64'hFFFF, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    // ADD x6,x5,x0 ; then with same-cycle bypass of x5 ; ADD x6,x0,x0 with x0 bypass attempt
    vecs.push_back(mk(1, 32'h00028333, 64'h100, 0, 0, 0, 0, 0, 0,        1, 0, 0, 1, 9'h100, 64'h1234, 0, 0, 6));
    vecs.push_back(mk(1, 32'h00028333, 64'h104, 0, 0, 0, 1, 5, 64'hBEEF, 1, 0, 0, 1, 9'h100, 64'hBEEF, 0, 0, 6));
    vecs.push_back(mk(1, 32'h00000333, 64'h108, 0, 0, 0, 1, 0, 64'hFFFF, 1, 0, 0, 1, 9'h100, 0, 0, 0, 6));
    // Load-use on rs1, re-presented without load, then load-use on rs2
    vecs.push_back(mk(1, 32'h00138433, 64'h10C, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h00138433, 64'h10C, 0, 0, 7, 0, 0, 0, 1, 0, 0, 1, 9'h100, 64'h77, 64'h11, 0, 8));
    vecs.push_back(mk(1, 32'h00138433, 64'h110, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // LUI x8 with EX rd=8 load: no stall (rs1 field is 8 but unused)
    vecs.push_back(mk(1, 32'h12345437, 64'h114, 0, 1, 8, 0, 0, 0, 1, 0, 0, 1, 9'h110, 0, 0, 64'h12345000, 8));
    // ADDI x3,x2,-1 with EX rd=31 load: rs2 field 31 unused, no stall
    vecs.push_back(mk(1, 32'hFFF10193, 64'h118, 0, 1, 31, 0, 0, 0, 1, 0, 0, 1, 9'h110, 64'h22, 0, 64'hFFFFFFFFFFFFFFFF, 3));
    // Load to x0 never stalls
    vecs.push_back(mk(1, 32'h00000333, 64'h11C, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 9'h100, 0, 0, 0, 6));
    // SW x5,8(x2) and BEQ x1,x2,-4
    vecs.push_back(mk(1, 32'h00512423, 64'h120, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 9'h050, 64'h22, 64'hBEEF, 64'h8, 8));
    vecs.push_back(mk(1, 32'hFE208EE3, 64'h124, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 9'h008, 64'h11, 64'h22, 64'hFFFFFFFFFFFFFFFC, 29));
    // JAL x1,+0x100 and JAL x1,-0x40 at pc 0x40
    vecs.push_back(mk(1, 32'h100000EF, 64'h40, 0, 0, 0, 0, 0, 0, 1, 1, 64'h140, 1, 9'h104, 0, 0, 64'h100, 1));
    vecs.push_back(mk(1, 32'hFC1FF0EF, 64'h40, 0, 0, 0, 0, 0, 0, 1, 1, 64'h0, 1, 9'h104, 0, 64'h11, 64'hFFFFFFFFFFFFFFC0, 1));
    // JALR x1,0(x2): load-use stall on rs1, then issue
    vecs.push_back(mk(1, 32'h000100E7, 64'h134, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h000100E7, 64'h134, 0, 0, 2, 0, 0, 0, 1, 0, 0, 1, 9'h112, 64'h22, 0, 0, 1));
    // Flush with a load-use hazard present, then flush with JAL in ID
    vecs.push_back(mk(1, 32'h00138433, 64'h128, 1, 1, 7, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h100000EF, 64'h40, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    // Unsupported opcode; hazard pattern without valid
    vecs.push_back(mk(1, 32'h0000007F, 64'h12C, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h00138433, 64'h130, 0, 1, 7, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset with a JAL presented: fetch-side outputs must stay quiet
    rst_n = 1'b0;
    i_if_valid = 1'b1; i_if_instr = 32'h100000EF; i_if_pc = 64'h40;
    i_PCsrc = 1'b0; i_ex_memread = 1'b0; i_ex_rd = '0;
    i_wb_wen = 1'b0; i_wb_rd = '0; i_wb_data = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst.idex_valid", 64'(o_idex_valid), 64'd0);
    chk("rst.idex_ctrl", 64'(w_ctrl_bits), 64'd0);
    chk("rst.idex_pc", o_idex_pc, 64'd0);
    chk("rst.ready", 64'(o_id_ready), 64'd1);
    chk("rst.is_jump", 64'(o_is_jump), 64'd0);
    chk("rst.id_PC", o_id_PC, 64'd0);
    rst_n = 1'b1;
    i_if_valid = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) apply(vecs[i], i);

`ifdef ID_PERF_CNT_EN
    chk("perf.stall_cnt", 64'(o_stall_cnt), 64'd3);
    chk("perf.flush_cnt", 64'(o_flush_cnt), 64'd2);
`endif

    // Asynchronous reset mid-stream with a valid instruction in ID/EX
    apply(mk(1, 32'h00028333, 64'h200, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 9'h100, 64'hBEEF, 0, 0, 6), 100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst.idex_valid", 64'(o_idex_valid), 64'd0);
    chk("async_rst.idex_rs1_data", o_idex_rs1_data, 64'd0);
    chk("async_rst.idex_ctrl", 64'(w_ctrl_bits), 64'd0);
`ifdef ID_PERF_CNT_EN
    chk("async_rst.stall_cnt", 64'(o_stall_cnt), 64'd0);
    chk("async_rst.flush_cnt", 64'(o_flush_cnt), 64'd0);
`endif
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // x5 and x7 were cleared by reset
    apply(mk(1, 32'h00028333, 64'h204, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 9'h100, 0, 0, 0, 6), 101);
    apply(mk(1, 32'h00138433, 64'h208, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 9'h100, 0, 0, 0, 8), 102);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
